// File: rtl/gcd_requester.sv
// Initiator for the GCD engine start/done handshake: operand FIFO, single-job issue,
// result capture with sequence tag, and a watchdog that retires jobs whose done never comes.
module gcd_requester #(
    parameter int NBITS       = 32,
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [NBITS-1:0] op_a,
    input  logic [NBITS-1:0] op_b,
    output logic [NBITS-1:0] eng_a,
    output logic [NBITS-1:0] eng_b,
    output logic             eng_start,
    input  logic [NBITS-1:0] eng_result,
    input  logic             eng_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [NBITS-1:0] res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, FLUSH} state_t;

    state_t             state, state_nx;
    logic [NBITS-1:0]   fifo_a [DEPTH];
    logic [NBITS-1:0]   fifo_b [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [WD_W-1:0]    wd;
    logic [TAG_W-1:0]   tag;
    logic               flush_pend;
    logic               full, empty, push, pop;
    logic               done_ok, timed_out;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign push      = op_valid && !full;
    assign done_ok   = (state == WAIT) && eng_done;
    assign timed_out = (state == WAIT) && !eng_done && (wd == WD_W'(TIMEOUT_CYC - 1));
    // The job stays at the FIFO head while in flight; it is only popped when retired.
    assign pop       = done_ok || timed_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (!empty) state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (pop) state_nx = HOLD;
            // A late done seen while holding the timeout result cancels the flush.
            HOLD:  if (res_ready) state_nx = (flush_pend && !eng_done) ? FLUSH : IDLE;
            FLUSH: if (eng_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        eng_start = (state == ISSUE);
        op_ready  = !full;
        busy      = (state != IDLE) || !empty;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr] <= op_a;
            fifo_b[wr_ptr] <= op_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eng_a      <= '0;
            eng_b      <= '0;
            wd         <= '0;
            tag        <= '0;
            flush_pend <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_tag    <= '0;
            res_err    <= 1'b0;
        end else begin
            if (state == IDLE && !empty) begin
                eng_a <= fifo_a[rd_ptr];
                eng_b <= fifo_b[rd_ptr];
            end
            if (state == ISSUE)     wd <= '0;
            else if (state == WAIT) wd <= wd + 1'b1;

            if (done_ok) begin
                res_data <= eng_result;
                res_err  <= 1'b0;
            end else if (timed_out) begin
                res_data <= '0;
                res_err  <= 1'b1;
            end
            if (pop) begin
                res_tag   <= tag;
                res_valid <= 1'b1;
                tag       <= tag + 1'b1;
            end else if (state == HOLD && res_ready) begin
                res_valid <= 1'b0;
            end

            if (timed_out)
                flush_pend <= 1'b1;
            else if ((state == HOLD || state == FLUSH) && eng_done)
                flush_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gcd_requester.sv
// Randomized scoreboard bench for gcd_requester with a behavioural GCD engine model.
module tb_gcd_requester;

    localparam int NB = 32;
    localparam int D  = 4;
    localparam int TW = 4;
    localparam int T  = 32;

    logic          clk, reset_n;
    logic          op_valid, op_ready;
    logic [NB-1:0] op_a, op_b, eng_a, eng_b, eng_result, res_data;
    logic          eng_start, eng_done, res_valid, res_ready, res_err, busy;
    logic [TW-1:0] res_tag;

    gcd_requester #(.NBITS(NB), .DEPTH(D), .TAG_W(TW), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset_n(reset_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .eng_a(eng_a), .eng_b(eng_b), .eng_start(eng_start),
        .eng_result(eng_result), .eng_done(eng_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_err(res_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] data;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   dly_q[$];
    int   tests = 0;
    int   fails = 0;
    int   njobs = 0;
    int   rr_mode = 0;
    int   spur_req = 0;
    int   spur_ack = 0;
    logic prev_start = 1'b0;

    function automatic logic [NB-1:0] gcd_ref(logic [NB-1:0] a, logic [NB-1:0] b);
        logic [NB-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(string name);
        tests++;
        fails++;
        $display("FAIL %s: got event expected none/complete", name);
    endtask

    // A job whose done arrives after the watchdog window retires as an error with data 0.
    function automatic void push_exp(logic [NB-1:0] a, logic [NB-1:0] b, int d);
        exp_t e;
        e.err  = (d > T);
        e.data = e.err ? '0 : gcd_ref(a, b);
        e.tag  = TW'(njobs % (1 << TW));
        exp_q.push_back(e);
        dly_q.push_back(d);
        njobs++;
    endfunction

    task automatic push_op(logic [NB-1:0] a, logic [NB-1:0] b, int d);
        bit acc = 0;
        @(negedge clk);
        op_valid = 1'b1;
        op_a = a;
        op_b = b;
        for (int i = 0; i < 3000 && !acc; i++) begin
            if (op_ready) begin
                @(posedge clk);
                acc = 1;
                push_exp(a, b, d);
            end else begin
                @(negedge clk);
            end
        end
        if (!acc) flag("push_timeout");
        #1 op_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !res_valid) ok = 1;
        end
        if (!ok) flag("drain_timeout");
    endtask

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            res_ready = (rr_mode == 1) ? 1'b1 : (rr_mode == 2) ? 1'($urandom % 2) : 1'b0;
        end
    end

    // Engine model: latch operands on start, answer after the job's chosen delay.
    initial begin
        logic [NB-1:0] ca, cb;
        int d;
        bit aborted;
        eng_done = 1'b0;
        eng_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) continue;
            if (eng_start) begin
                ca = eng_a;
                cb = eng_b;
                if (dly_q.size() == 0) begin
                    flag("unexpected_start");
                    d = 1;
                end else begin
                    d = dly_q.pop_front();
                end
                aborted = 0;
                for (int i = 0; i < d && !aborted; i++) begin
                    @(posedge clk);
                    if (!reset_n) aborted = 1;
                end
                #1;
                if (!aborted && reset_n) begin
                    check("eng_a_stable", 64'(eng_a), 64'(ca));
                    check("eng_b_stable", 64'(eng_b), 64'(cb));
                    eng_result = gcd_ref(ca, cb);
                    eng_done = 1'b1;
                    @(posedge clk);
                    #1 eng_done = 1'b0;
                end
            end else if (spur_req != spur_ack) begin
                eng_result = NB'($urandom);
                eng_done = 1'b1;
                @(posedge clk);
                #1 eng_done = 1'b0;
                spur_ack++;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_start = 1'b0;
            end else begin
                if (eng_start) check("start_pulse_width", 64'(prev_start), 64'd0);
                prev_start = eng_start;
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        flag("unexpected_result");
                    end else begin
                        e = exp_q.pop_front();
                        check("res_data", 64'(res_data), 64'(e.data));
                        check("res_tag",  64'(res_tag),  64'(e.tag));
                        check("res_err",  64'(res_err),  64'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [NB-1:0] pa[6], pb[6];
        int idx;

        reset_n = 1'b0;
        op_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_op_ready",  64'(op_ready),  64'd1);
        check("rst_eng_start", 64'(eng_start), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_res_tag",   64'(res_tag),   64'd0);
        @(negedge clk) reset_n = 1'b1;

        // Basic job with issue latency check, then a zero operand
        rr_mode = 1;
        push_op(48, 18, 6);
        check("lat_pre_start", 64'(eng_start), 64'd0);
        @(posedge clk);
        #1 check("lat_start", 64'(eng_start), 64'd1);
        push_op(7, 0, 3);
        wait_drain();

        // Backpressure: downstream stalled, one job in flight popped after its done
        rr_mode = 0;
        for (int i = 0; i < 6; i++) begin
            pa[i] = NB'($urandom_range(1, 5000) * 6);
            pb[i] = NB'($urandom_range(1, 5000) * 4);
        end
        idx = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (idx < 6) begin
                op_valid = 1'b1;
                op_a = pa[idx];
                op_b = pb[idx];
                if (op_ready) begin
                    @(posedge clk);
                    push_exp(pa[idx], pb[idx], 4);
                    idx++;
                    #1 op_valid = 1'b0;
                end
            end
        end
        op_valid = 1'b0;
        check("bp_accepts", 64'(idx), 64'(D + 1));
        check("bp_op_ready", 64'(op_ready), 64'd0);
        rr_mode = 1;
        while (idx < 6) begin
            push_op(pa[idx], pb[idx], 4);
            idx++;
        end
        wait_drain();

        // Timeouts: late done in FLUSH, late done during HOLD, then done on the last watchdog cycle
        push_op(100, 75, T + 5);
        push_op(81, 27, 3);
        push_op(64, 40, T + 1);
        push_op(35, 21, 4);
        push_op(90, 60, T);
        push_op(17, 5, 2);
        wait_drain();
        rr_mode = 2;
        push_op(144, 96, T + 3);
        push_op(30, 45, 5);
        wait_drain();

        // Reset with a job in WAIT and three entries queued
        rr_mode = 1;
        push_op(1000, 10, 20);
        push_op(55, 11, 20);
        push_op(9, 6, 20);
        repeat (3) @(posedge clk);
        #1 check("pre_rst_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("async_op_ready",  64'(op_ready),  64'd1);
        check("async_eng_start", 64'(eng_start), 64'd0);
        check("async_eng_a",     64'(eng_a),     64'd0);
        check("async_eng_b",     64'(eng_b),     64'd0);
        check("async_res_valid", 64'(res_valid), 64'd0);
        check("async_res_data",  64'(res_data),  64'd0);
        check("async_res_tag",   64'(res_tag),   64'd0);
        check("async_res_err",   64'(res_err),   64'd0);
        check("async_busy",      64'(busy),      64'd0);
        exp_q.delete();
        dly_q.delete();
        njobs = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("no_stale_result", 64'(res_valid), 64'd0);
        push_op(12, 8, 2);
        wait_drain();

        // Tag wrap with random traffic and spurious done pulses while idle
        rr_mode = 2;
        for (int j = 0; j < (1 << TW) + 2; j++) begin
            push_op(NB'($urandom_range(0, 100000)), NB'(($urandom % 4 == 0) ? 0 : $urandom_range(1, 100000)),
                    $urandom_range(1, 8));
            if (j % 6 == 5) begin
                wait_drain();
                spur_req++;
                repeat (4) @(posedge clk);
                #1 check("spurious_done", 64'(res_valid), 64'd0);
                check("spurious_busy", 64'(busy), 64'd0);
            end
        end
        wait_drain();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
